// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: serial input and received-byte outputs of the UART receiver.
//   rxd       - asynchronous serial line, idle high
//   rx_data   - last correctly framed byte
//   rx_valid  - one-cycle strobe, rx_data valid from this cycle on
//   frame_err - one-cycle strobe, stop bit sampled low
//   busy      - receiver is inside a frame
// master: the receiver core. slave: line driver / byte consumer.
interface uart_rx_core_if;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rxd,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rxd,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with internal baud counter, mid-bit
// sampling and start-bit glitch rejection.
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - uart_rx_core_if.master (rxd in; rx_data, rx_valid, frame_err, busy out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle, waiting for a high->low edge on the synced input
// START | half a bit into the start bit, confirm it is still low
// DATA  | sampling the 8 data bits one bit period apart (LSB first)
// STOP  | sampling the stop bit; high -> byte out, low -> frame error
module uart_rx_core #(
    parameter  int CLK_FREQ = 200000000,
    parameter  int BAUD     = 115200,
    localparam int TOTAL    = CLK_FREQ / BAUD - 1,
    localparam int HALF     = TOTAL / 2
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_core_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] CNT_TOTAL = 16'(TOTAL);
    localparam logic [15:0] CNT_HALF  = 16'(HALF);

    state_t      state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [2:0]  idx, idx_next;
    logic [7:0]  shift, shift_next;
    logic        cnt_clr;
    logic        load_byte;
    logic        set_err;

    logic        rxd_s1, rxd_s2, rxd_d;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        frame_err_q;

    // Synchronizer and edge-detect flops reset to the idle (high) level.
    // Because rxd_d must have been high, a line held low (break) cannot
    // retrigger reception after a frame error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= bus.rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        shift_next = shift;
        cnt_clr    = 1'b0;
        load_byte  = 1'b0;
        set_err    = 1'b0;

        case (state)
            IDLE: begin
                if (!rxd_s2 && rxd_d) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    if (!rxd_s2) begin
                        state_next = DATA;
                        idx_next   = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                // Counter restarted at mid start bit, so TOTAL lands mid data bit.
                if (cnt == CNT_TOTAL) begin
                    shift_next = {rxd_s2, shift[7:1]};
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                        cnt_clr  = 1'b1;
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch the
                // next start edge of a back-to-back frame.
                if (cnt == CNT_TOTAL) begin
                    state_next = IDLE;
                    if (rxd_s2) begin
                        load_byte = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state == IDLE || cnt_clr || state_next != state) begin
            cnt_next = 16'd0;
        end else begin
            cnt_next = cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            idx         <= 3'd0;
            shift       <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shift       <= shift_next;
            rx_valid_q  <= load_byte;
            frame_err_q <= set_err;
            if (load_byte) begin
                rx_data_q <= shift;
            end
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core at 16 clocks per bit
// (CLK_FREQ=1600000, BAUD=100000 -> TOTAL=15, HALF=7).
module tb_uart_rx_core;

    localparam int BIT_CLKS = 16;

    logic clk;
    logic rst;

    uart_rx_core_if sif ();

    uart_rx_core #(
        .CLK_FREQ (1600000),
        .BAUD     (100000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int         valid_cnt = 0;
    int         err_cnt   = 0;
    int         valid_cyc = 0;
    logic       both_seen = 1'b0;
    logic [7:0] got [0:255];

    always @(negedge clk) begin
        if (sif.rx_valid === 1'b1) begin
            got[valid_cnt] = sif.rx_data;
            valid_cnt      = valid_cnt + 1;
            valid_cyc      = cyc;
        end
        if (sif.frame_err === 1'b1) begin
            err_cnt = err_cnt + 1;
        end
        if (sif.rx_valid === 1'b1 && sif.frame_err === 1'b1) begin
            both_seen = 1'b1;
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int start_cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp)
        else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        vectors = vectors + 1;
        assert (obs >= lo && obs <= hi)
        else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge with
    // the line left at the stop-bit level. rst_bit >= 0 pulses reset for one
    // edge in the middle of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int rst_bit);
        sif.rxd   = 1'b0;
        start_cyc = cyc + 1;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            sif.rxd = d[i];
            if (i == rst_bit) begin
                repeat (8) @(posedge clk);
                #1 rst = 1'b0;
                @(posedge clk);
                #1 rst = 1'b1;
                repeat (BIT_CLKS - 9) @(posedge clk);
                #1;
            end else begin
                repeat (BIT_CLKS) @(posedge clk);
                #1;
            end
        end
        sif.rxd = stop_b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    int v0, e0;

    initial begin
        rst     = 1'b0;
        sif.rxd = 1'b1;

        // Reset
        repeat (5) @(posedge clk);
        #1;
        chk("rst_rx_data", 32'(sif.rx_data), 32'h00);
        chk("rst_rx_valid", 32'(sif.rx_valid), 32'h0);
        chk("rst_frame_err", 32'(sif.frame_err), 32'h0);
        chk("rst_busy", 32'(sif.busy), 32'h0);
        rst = 1'b1;
        v0 = valid_cnt;
        e0 = err_cnt;
        repeat (200) @(posedge clk);
        #1;
        chk("idle_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        chk("idle_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("idle_busy", 32'(sif.busy), 32'h0);

        // Single frame 0x55: 3 + 7 + 9*16 = 154 cycles to rx_valid
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h55, 1'b1, -1);
        chk("f55_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("f55_got", 32'(got[v0]), 32'h55);
        chk("f55_rx_data", 32'(sif.rx_data), 32'h55);
        chk("f55_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk_rng("f55_latency", valid_cyc - start_cyc, 152, 156);
        chk("f55_busy_after", 32'(sif.busy), 32'h0);

        // Back-to-back 0xA5, 0x00, 0xFF
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'hA5, 1'b1, -1);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd3);
        chk("b2b_got0", 32'(got[v0]), 32'hA5);
        chk("b2b_got1", 32'(got[v0 + 1]), 32'h00);
        chk("b2b_got2", 32'(got[v0 + 2]), 32'hFF);
        chk("b2b_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("b2b_rx_data", 32'(sif.rx_data), 32'hFF);

        // Glitch: 5 clocks low is shorter than HALF+1
        v0 = valid_cnt;
        e0 = err_cnt;
        sif.rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1 sif.rxd = 1'b1;
        chk("glitch_busy_high", 32'(sif.busy), 32'h1);
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_busy_low", 32'(sif.busy), 32'h0);
        chk("glitch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        chk("glitch_err_cnt", 32'(err_cnt - e0), 32'd0);
        send_frame(8'h3C, 1'b1, -1);
        chk("glitch_follow_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("glitch_follow_data", 32'(sif.rx_data), 32'h3C);

        // Framing error followed by a long break
        send_frame(8'h12, 1'b1, -1);
        chk("fe_pre_data", 32'(sif.rx_data), 32'h12);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0, -1);
        repeat (40 * BIT_CLKS) @(posedge clk);
        #1;
        chk("fe_err_cnt", 32'(err_cnt - e0), 32'd1);
        chk("fe_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        chk("fe_rx_data", 32'(sif.rx_data), 32'h12);
        sif.rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h81, 1'b1, -1);
        chk("fe_follow_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("fe_follow_data", 32'(sif.rx_data), 32'h81);
        chk("fe_follow_err", 32'(err_cnt - e0), 32'd0);

        // Reset during data bit 4 of 0xC3
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'hC3, 1'b1, 4);
        chk("mrst_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        chk("mrst_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("mrst_rx_data", 32'(sif.rx_data), 32'h00);
        // Bits 4 and 5 are low, so the receiver resyncs onto the remainder
        // of the aborted frame; let that finish on an idle line first.
        repeat (300) @(posedge clk);
        #1;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h7E, 1'b1, -1);
        chk("mrst_follow_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("mrst_follow_got", 32'(got[v0]), 32'h7E);
        chk("mrst_follow_data", 32'(sif.rx_data), 32'h7E);
        chk("mrst_follow_err", 32'(err_cnt - e0), 32'd0);
        chk_rng("mrst_follow_latency", valid_cyc - start_cyc, 152, 156);

        chk("valid_err_overlap", 32'(both_seen), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
